// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel dispatcher and its raster counter.
package pixel_pkg;

   localparam int MAX_CORES  = 4;
   localparam int CORE_IDX_W = 2;
   localparam int DEF_X_W    = 10;
   localparam int DEF_Y_W    = 10;

   typedef enum logic [1:0] {
      IDLE,
      DISPATCH,
      DONE
   } dispatch_state_t;

   // Extra-core requests beyond the physical array collapse onto the last core.
   function automatic logic [CORE_IDX_W-1:0] clamp_cores(input logic [2:0] n);
      return (n > 3'(MAX_CORES - 1)) ? CORE_IDX_W'(MAX_CORES - 1) : n[CORE_IDX_W-1:0];
   endfunction

   function automatic logic [MAX_CORES-1:0] core_onehot(input logic [CORE_IDX_W-1:0] idx);
      return MAX_CORES'(1) << idx;
   endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y position counter with wrap at the latched frame size.
// The x_next_o port exists only when PIXEL_DISPATCHER_SOF_EOL_EN is defined.
module raster_counter
   import pixel_pkg::*;
#(
   parameter int X_W = DEF_X_W,
   parameter int Y_W = DEF_Y_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clear_i,
   input  logic           advance_i,
   input  logic [X_W-1:0] width_i,
   input  logic [Y_W-1:0] height_i,
   output logic [X_W-1:0] x_o,
   output logic [Y_W-1:0] y_o,
`ifdef PIXEL_DISPATCHER_SOF_EOL_EN
   output logic [X_W-1:0] x_next_o,
`endif
   output logic           last_pixel_o
);

   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;
   logic           x_at_end;

   assign x_at_end     = (x_q == width_i - X_W'(1));
   assign last_pixel_o = x_at_end && (y_q == height_i - Y_W'(1));

   always_comb begin
      // NOTE: defaults first, so every path assigns x_d/y_d and no latch is inferred.
      x_d = x_q;
      y_d = y_q;
      if (clear_i) begin
         x_d = '0;
         y_d = '0;
      end else if (advance_i) begin
         if (x_at_end) begin
            x_d = '0;
            y_d = y_q + Y_W'(1);
         end else begin
            x_d = x_q + X_W'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments only; the reset is asynchronous.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x_o = x_q;
   assign y_o = y_q;
`ifdef PIXEL_DISPATCHER_SOF_EOL_EN
   assign x_next_o = x_d;
`endif

endmodule

// File: rtl/pixel_dispatcher.sv
// Hands raster-ordered (x, y) coordinates to up to four compute cores in strict rotation.
// Define PIXEL_DISPATCHER_SOF_EOL_EN to add the registered sof/eol side-band outputs.
module pixel_dispatcher
   import pixel_pkg::*;
#(
   parameter int X_W = DEF_X_W,
   parameter int Y_W = DEF_Y_W
) (
   input  logic           aclk,
   input  logic           aresetn,
   input  logic           start,
   input  logic [X_W-1:0] frame_width,
   input  logic [Y_W-1:0] frame_height,
   input  logic [2:0]     no_of_extra_cores,
   input  logic           compute_ready_1,
   input  logic           compute_ready_2,
   input  logic           compute_ready_3,
   input  logic           compute_ready_4,
   output logic           valid1,
   output logic           valid2,
   output logic           valid3,
   output logic           valid4,
   output logic [X_W-1:0] x_out,
   output logic [Y_W-1:0] y_out,
   output logic           busy,
`ifdef PIXEL_DISPATCHER_SOF_EOL_EN
   output logic           sof,
   output logic           eol,
`endif
   output logic           frame_done
);

   dispatch_state_t         state_q;
   logic [CORE_IDX_W-1:0]   core_q, cores_q, core_nxt;
   logic [X_W-1:0]          width_q;
   logic [Y_W-1:0]          height_q;
   logic [MAX_CORES-1:0]    valid_q, ready_vec;
   logic                    transfer, accept_start, last_pixel;
`ifdef PIXEL_DISPATCHER_SOF_EOL_EN
   logic                    sof_q, eol_q;
   logic [X_W-1:0]          x_next;
`endif

   assign ready_vec    = {compute_ready_4, compute_ready_3, compute_ready_2, compute_ready_1};
   // Only the selected core's valid is ever high, so the masked OR ignores other readies.
   assign transfer     = (state_q == DISPATCH) && |(valid_q & ready_vec);
   assign accept_start = (state_q == IDLE) && start;
   assign core_nxt     = (core_q == cores_q) ? '0 : core_q + CORE_IDX_W'(1);

   raster_counter #(.X_W(X_W), .Y_W(Y_W)) u_raster (
      .clk          (aclk),
      .rst_n        (aresetn),
      .clear_i      (accept_start),
      .advance_i    (transfer),
      .width_i      (width_q),
      .height_i     (height_q),
      .x_o          (x_out),
      .y_o          (y_out),
`ifdef PIXEL_DISPATCHER_SOF_EOL_EN
      .x_next_o     (x_next),
`endif
      .last_pixel_o (last_pixel)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= IDLE;
         core_q   <= '0;
         cores_q  <= '0;
         width_q  <= '0;
         height_q <= '0;
         valid_q  <= '0;
`ifdef PIXEL_DISPATCHER_SOF_EOL_EN
         sof_q    <= 1'b0;
         eol_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  width_q  <= frame_width;
                  height_q <= frame_height;
                  cores_q  <= clamp_cores(no_of_extra_cores);
                  core_q   <= '0;
                  if (frame_width == '0 || frame_height == '0) begin
                     state_q <= DONE;
                  end else begin
                     state_q <= DISPATCH;
                     valid_q <= core_onehot('0);
`ifdef PIXEL_DISPATCHER_SOF_EOL_EN
                     sof_q   <= 1'b1;
                     eol_q   <= (frame_width == X_W'(1));
`endif
                  end
               end
            end
            DISPATCH: begin
               if (transfer) begin
                  if (last_pixel) begin
                     state_q <= DONE;
                     valid_q <= '0;
`ifdef PIXEL_DISPATCHER_SOF_EOL_EN
                     sof_q   <= 1'b0;
                     eol_q   <= 1'b0;
`endif
                  end else begin
                     core_q  <= core_nxt;
                     valid_q <= core_onehot(core_nxt);
`ifdef PIXEL_DISPATCHER_SOF_EOL_EN
                     sof_q   <= 1'b0;
                     eol_q   <= (x_next == width_q - X_W'(1));
`endif
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign valid1     = valid_q[0];
   assign valid2     = valid_q[1];
   assign valid3     = valid_q[2];
   assign valid4     = valid_q[3];
   assign busy       = (state_q != IDLE);
   assign frame_done = (state_q == DONE);
`ifdef PIXEL_DISPATCHER_SOF_EOL_EN
   assign sof        = sof_q;
   assign eol        = eol_q;
`endif

endmodule

// File: doc/pixel_dispatcher.md
Name: pixel_dispatcher

Overview:
- Work distributor at the head of the ray-tracing compute array; the counterpart of the output pixel collector.
- On start, walks the frame in raster order and hands one (x, y) coordinate at a time to compute cores 1..(no_of_extra_cores+1), strictly round-robin, using a valid/ready handshake per core.
- The strict rotation is what lets the downstream collector read core results back in the same fixed order.

Parameters:
X_W, 10, width of x coordinate and frame_width
Y_W, 10, width of y coordinate and frame_height
Core count is fixed at 4 (numbered ports); not a parameter.

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
start  in  1  single-cycle frame start request; honoured only in IDLE
frame_width  in  X_W  pixels per line; sampled at accepted start
frame_height  in  Y_W  lines per frame; sampled at accepted start
no_of_extra_cores  in  3  active cores minus 1; sampled at start; values >3 clamp to 3
compute_ready_1..4  in  1 each  core n can accept a coordinate
valid1..4  out  1 each  coordinate on x_out/y_out is offered to core n
x_out  out  X_W  current pixel x, shared by all cores
y_out  out  Y_W  current pixel y, shared by all cores
busy  out  1  high in DISPATCH and DONE
frame_done  out  1  one-cycle pulse after the last coordinate is accepted

Behaviour:
- Reset (async, any time, including mid-frame): state=IDLE; all outputs 0; x, y and core index = 0; latched config = 0.
- All outputs are registered or decoded directly from registered state. No combinational path from compute_ready_n to any output.
- States: IDLE, DISPATCH, DONE. The state type lives in the package.
- IDLE:
  - On start: latch frame_width, frame_height and the clamped core count; set x=0, y=0, core=0.
  - If width or height is 0, go to DONE; otherwise go to DISPATCH.
- DISPATCH:
  - valid(core+1) is high; all other valids are low. x_out/y_out hold the current coordinate.
  - Transfer happens when valid(core+1) && compute_ready(core+1).
  - Without a transfer, valid, x_out and y_out hold stable.
  - compute_ready on non-selected cores is ignored.
  - On transfer:
    - If x == width-1 and y == height-1: go to DONE with all valids low.
    - Else if x == width-1: x=0, y=y+1.
    - Else: x=x+1.
    - core = (core == cores_latched) ? 0 : core+1.
- DONE: frame_done=1 for exactly one cycle, then IDLE.
- Latency and throughput:
  - start accepted in cycle N gives valid1 high in cycle N+1.
  - Back-to-back transfers give one coordinate per cycle with no bubbles.
  - Last transfer in cycle M gives frame_done in cycle M+1; busy is low and start is accepted from cycle M+2.
- start in DISPATCH or DONE is ignored (not queued).
- Changes to config inputs after start are ignored until the next accepted start.
- Counter arithmetic is unsigned and uses the exact widths. frame_width = 2^X_W-1 is legal; no overflow is possible because wrap happens at width-1.

Optional Feature:
- Macro: PIXEL_DISPATCHER_SOF_EOL_EN
- Defined: adds outputs sof (1 bit; high when the offered coordinate is (0,0)) and eol (1 bit; high when x_out == width-1). Both are registered, have the same timing as x_out, and are 0 at reset and whenever all valids are low.
- Undefined: these ports and their logic are absent; everything else is unchanged.

Decomposition:
- Shared package pixel_pkg:
  - dispatch_state_t (IDLE/DISPATCH/DONE)
  - MAX_CORES=4, CORE_IDX_W=2
  - default X_W/Y_W constants
- One sub-module, raster_counter: x/y registers with wrap against latched width/height, plus a last_pixel flag. It is instantiated once; the dispatcher owns the FSM and the core rotation.

Test Plan:
- Basic rotation: width=3, height=2, no_of_extra_cores=1, all ready=1 → transfers (0,0)c1, (1,0)c2, (2,0)c1, (0,1)c2, (1,1)c1, (2,1)c2 on six consecutive cycles; frame_done one cycle after the 6th; busy low the cycle after that.
- Backpressure: width=4, height=1, cores=4, compute_ready_1 low for 5 cycles after start → valid1 held with x_out=0, y_out=0 stable; valid2..4 stay 0; (1,0) goes to core 2 only after core 1 accepts.
- Clamp and zero size: no_of_extra_cores=7, width=4, height=1 → cores 1, 2, 3, 4 each receive one pixel. Separately, width=0, height=5 → no valid ever asserted; frame_done pulses at start+1.
- Ignored inputs: start pulsed mid-DISPATCH, and frame_width changed to 9 mid-frame → frame completes with the originally latched size; exactly one frame_done.
- Reset mid-frame: aresetn low after 2 transfers → all outputs 0 immediately (async). After release, start gives (0,0) on core 1.
- With PIXEL_DISPATCHER_SOF_EOL_EN, width=2, height=2 → sof only on (0,0); eol on (1,0) and (1,1).
